// File: rtl/fp_cvt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cvt_arbiter
//  Description : Round-robin arbiter sharing one combinational raw-single to
//                recoded-double rounding unit among NUM_REQ requesters.
//                Two-stage pipeline: operand stage (OP) drives cvt_raw, and
//                the result stage (RES) captures cvt_out. Tag and source
//                index travel with each operation.
//                Optional macro FP_CVT_ARB_PERF_EN adds the perf_grants and
//                perf_stalls counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_cvt_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*40-1:0]      req_raw,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [39:0]                cvt_raw,
    input  logic [64:0]                cvt_out,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [64:0]                resp_data,
    output logic [$clog2(NUM_REQ)-1:0] resp_src,
    output logic [TAG_W-1:0]           resp_tag
`ifdef FP_CVT_ARB_PERF_EN
    ,
    output logic [31:0]                perf_grants,
    output logic [31:0]                perf_stalls
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // Operand stage
    logic               r_opValid;
    logic [39:0]        r_cvtRaw;
    logic [SRC_W-1:0]   r_opSrc;
    logic [TAG_W-1:0]   r_opTag;

    // Result stage
    logic               r_respValid;
    logic [64:0]        r_respData;
    logic [SRC_W-1:0]   r_respSrc;
    logic [TAG_W-1:0]   r_respTag;

    // Arbitration state
    logic [SRC_W-1:0]   r_lastGrant;

    logic               w_resFree;
    logic               w_opAdvance;
    logic               w_opFree;
    logic               w_found;
    logic [SRC_W-1:0]   w_grantIdx;
    logic               w_grant;
    logic [39:0]        w_selRaw;
    logic [TAG_W-1:0]   w_selTag;

    // Pipeline flow control: RES drains, OP advances, OP becomes free
    always_comb begin
        w_resFree   = !r_respValid || resp_ready;
        w_opAdvance = r_opValid && w_resFree;
        w_opFree    = !r_opValid || w_opAdvance;
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin : p_arb
        int               idx;
        logic [SRC_W-1:0] cand;
        w_found    = 1'b0;
        w_grantIdx = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_lastGrant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = SRC_W'(idx);
            if (!w_found && req_valid[cand]) begin
                w_found    = 1'b1;
                w_grantIdx = cand;
            end
        end
    end

    // Grant only into a free OP stage, never during flush or reset
    always_comb begin
        w_grant   = reset && !flush && w_opFree && w_found;
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_grantIdx] = 1'b1;
        end
        w_selRaw = req_raw[int'(w_grantIdx)*40 +: 40];
        w_selTag = req_tag[int'(w_grantIdx)*TAG_W +: TAG_W];
    end

    // Operand stage and round-robin pointer; cvt_raw keeps its value when idle
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_opValid   <= 1'b0;
            r_cvtRaw    <= '0;
            r_opSrc     <= '0;
            r_opTag     <= '0;
            r_lastGrant <= SRC_W'(NUM_REQ - 1);
        end else if (flush) begin
            r_opValid <= 1'b0;
        end else if (w_grant) begin
            r_opValid   <= 1'b1;
            r_cvtRaw    <= w_selRaw;
            r_opSrc     <= w_grantIdx;
            r_opTag     <= w_selTag;
            r_lastGrant <= w_grantIdx;
        end else if (w_opAdvance) begin
            r_opValid <= 1'b0;
        end
    end

    // Result stage captures the shared unit output as OP advances
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_respValid <= 1'b0;
            r_respData  <= '0;
            r_respSrc   <= '0;
            r_respTag   <= '0;
        end else if (flush) begin
            r_respValid <= 1'b0;
        end else if (w_opAdvance) begin
            r_respValid <= 1'b1;
            r_respData  <= cvt_out;
            r_respSrc   <= r_opSrc;
            r_respTag   <= r_opTag;
        end else if (resp_ready) begin
            r_respValid <= 1'b0;
        end
    end

    assign cvt_raw    = r_cvtRaw;
    assign resp_valid = r_respValid;
    assign resp_data  = r_respData;
    assign resp_src   = r_respSrc;
    assign resp_tag   = r_respTag;

`ifdef FP_CVT_ARB_PERF_EN
    logic [31:0] r_perfGrants;
    logic [31:0] r_perfStalls;

    // Transfer and stall counters; they survive flush and wrap naturally
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perfGrants <= '0;
            r_perfStalls <= '0;
        end else begin
            if (w_grant) begin
                r_perfGrants <= r_perfGrants + 32'd1;
            end
            if ((|req_valid) && !(|req_ready)) begin
                r_perfStalls <= r_perfStalls + 32'd1;
            end
        end
    end

    assign perf_grants = r_perfGrants;
    assign perf_stalls = r_perfStalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_cvt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_cvt_arbiter
//  Description : Self-checking bench for fp_cvt_arbiter with a behavioural
//                model of the shared unit and of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_cvt_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 5;
    localparam int SRC_W   = 2;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*40-1:0]    req_raw;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [39:0]              cvt_raw;
    logic [64:0]              cvt_out;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [64:0]              resp_data;
    logic [SRC_W-1:0]         resp_src;
    logic [TAG_W-1:0]         resp_tag;
`ifdef FP_CVT_ARB_PERF_EN
    logic [31:0]              perf_grants;
    logic [31:0]              perf_stalls;
`endif

    int nErrors = 0;
    int nChecks = 0;

    typedef struct {
        logic [39:0]      raw;
        logic [TAG_W-1:0] tag;
        logic [SRC_W-1:0] src;
        int               cyc;
    } item_t;

    fp_cvt_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_raw    (req_raw),
        .req_tag    (req_tag),
        .cvt_raw    (cvt_raw),
        .cvt_out    (cvt_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag)
`ifdef FP_CVT_ARB_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    // Simplified unit: normal-number recoding of exponent and fraction
    function automatic logic [64:0] unitModel(input logic [39:0] raw);
        logic [11:0] e;
        e = {2'b00, raw[34:25]} + 12'h700;
        return {raw[35], e, raw[22:0], 29'd0};
    endfunction

    assign cvt_out = unitModel(cvt_raw);

    function automatic logic [39:0] rndRaw();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // First valid requester after 'last', wrapping around
    function automatic int rrPick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; flush = 1'b0; req_valid = '0; resp_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; req_valid = '1; resp_ready = 1'b1;
        req_raw = '0; req_tag = '0;
        tick(); tick();
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b000) begin nErrors++; $display("FAIL reset_ready actual=%b required=000", req_ready); end
        nChecks++; if (resp_valid !== 1'b0) begin nErrors++; $display("FAIL reset_resp_valid actual=%b required=0", resp_valid); end
        nChecks++; if (cvt_raw !== 40'd0) begin nErrors++; $display("FAIL reset_cvt_raw actual=%h required=0", cvt_raw); end
        nChecks++; if (resp_data !== 65'd0) begin nErrors++; $display("FAIL reset_resp_data actual=%h required=0", resp_data); end
        nChecks++; if (resp_src !== 2'd0 || resp_tag !== 5'd0) begin nErrors++; $display("FAIL reset_src_tag actual=%0d/%0d required=0/0", resp_src, resp_tag); end
        tick();
        reset = 1'b1; req_valid = '0;
    endtask

    task automatic test_single();
        logic [39:0] raw;
        raw = {4'b0000, 1'b0, 10'h100, 25'h0800000};
        req_raw[39:0] = raw; req_tag[4:0] = 5'h3; req_valid = 3'b001; resp_ready = 1'b1;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b001) begin nErrors++; $display("FAIL single_grant actual=%b required=001", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clock);
        nChecks++; if (resp_valid !== 1'b0) begin nErrors++; $display("FAIL single_early_valid actual=%b required=0", resp_valid); end
        nChecks++; if (cvt_raw !== raw) begin nErrors++; $display("FAIL single_cvt_raw actual=%h required=%h", cvt_raw, raw); end
        tick();
        @(negedge clock);
        nChecks++; if (resp_valid !== 1'b1) begin nErrors++; $display("FAIL single_valid actual=%b required=1", resp_valid); end
        nChecks++; if (resp_data !== 65'h0_8000_0000_0000_0000) begin nErrors++; $display("FAIL single_data actual=%h required=0_8000000000000000", resp_data); end
        nChecks++; if (resp_src !== 2'd0 || resp_tag !== 5'h3) begin nErrors++; $display("FAIL single_src_tag actual=%0d/%0h required=0/3", resp_src, resp_tag); end
        tick();
        @(negedge clock);
        nChecks++; if (resp_valid !== 1'b0) begin nErrors++; $display("FAIL single_drain actual=%b required=0", resp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [39:0]        raws [NUM_REQ];
        logic [NUM_REQ-1:0] expReady;
        logic [SRC_W-1:0]   s;
        int                 nResp;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            raws[i] = rndRaw();
            req_raw[i*40 +: 40] = raws[i];
            req_tag[i*TAG_W +: TAG_W] = 5'(20 + i);
        end
        req_valid = '1; resp_ready = 1'b1; nResp = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 9) req_valid = '0;
            @(negedge clock);
            expReady = (c < 9) ? 3'(1 << (c % 3)) : 3'b000;
            nChecks++; if (req_ready !== expReady) begin nErrors++; $display("FAIL rr_grant c=%0d actual=%b required=%b", c, req_ready, expReady); end
            nChecks++; if (resp_valid !== (c >= 2 && c < 11)) begin nErrors++; $display("FAIL rr_resp_valid c=%0d actual=%b required=%b", c, resp_valid, (c >= 2 && c < 11)); end
            if (resp_valid) begin
                nResp++;
                s = 2'((c - 2) % 3);
                nChecks++;
                if (resp_src !== s || resp_tag !== 5'(20 + int'(s)) || resp_data !== unitModel(raws[s])) begin
                    nErrors++; $display("FAIL rr_resp c=%0d actual=%0d/%0d/%h required=%0d/%0d/%h", c, resp_src, resp_tag, resp_data, s, 20 + int'(s), unitModel(raws[s]));
                end
            end
            tick();
        end
        nChecks++; if (nResp != 9) begin nErrors++; $display("FAIL rr_count actual=%0d required=9", nResp); end
    endtask

    task automatic test_backpressure();
        logic [39:0] raws [4];
        int accepted, waited, nResp;
        logic gotIt;
        apply_reset();
        for (int i = 0; i < 4; i++) raws[i] = rndRaw();
        accepted = 0; waited = 0; nResp = 0;
        req_raw = '0; req_tag = '0;
        req_raw[79:40] = raws[0]; req_tag[9:5] = 5'd10; req_valid = 3'b010; resp_ready = 1'b0;
        for (int c = 0; c < 25 && nResp < 4; c++) begin
            if (c == 5) resp_ready = 1'b1;
            @(negedge clock);
            if (c >= 2 && c < 5) begin
                nChecks++; if (req_ready !== 3'b000) begin nErrors++; $display("FAIL bp_ready_held c=%0d actual=%b required=000", c, req_ready); end
            end
            if (c == 4) begin
                nChecks++; if (accepted != 2) begin nErrors++; $display("FAIL bp_accepted actual=%0d required=2", accepted); end
                nChecks++; if (cvt_raw !== raws[1] || resp_data !== unitModel(raws[0]) || resp_tag !== 5'd10) begin
                    nErrors++; $display("FAIL bp_hold actual=%h/%h/%0d required=%h/%h/10", cvt_raw, resp_data, resp_tag, raws[1], unitModel(raws[0]));
                end
            end
            gotIt = req_ready[1];
            if (req_valid[1] && !gotIt) waited++;
            if (resp_valid && resp_ready) begin
                nChecks++;
                if (resp_src !== 2'd1 || resp_tag !== 5'(10 + nResp) || resp_data !== unitModel(raws[nResp])) begin
                    nErrors++; $display("FAIL bp_resp n=%0d actual=%0d/%0d required=1/%0d", nResp, resp_src, resp_tag, 10 + nResp);
                end
                nResp++;
            end
            tick();
            if (gotIt) begin
                accepted++;
                if (accepted < 4) begin
                    req_raw[79:40] = raws[accepted]; req_tag[9:5] = 5'(10 + accepted);
                end else begin
                    req_valid = '0;
                end
            end
        end
        nChecks++; if (nResp != 4 || accepted != 4) begin nErrors++; $display("FAIL bp_total actual=%0d/%0d required=4/4", nResp, accepted); end
`ifdef FP_CVT_ARB_PERF_EN
        nChecks++; if (perf_grants !== 32'd4) begin nErrors++; $display("FAIL perf_grants actual=%0d required=4", perf_grants); end
        nChecks++; if (perf_stalls !== 32'(waited)) begin nErrors++; $display("FAIL perf_stalls actual=%0d required=%0d", perf_stalls, waited); end
`endif
    endtask

    task automatic test_flush();
        int nResp;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_raw[i*40 +: 40] = rndRaw();
            req_tag[i*TAG_W +: TAG_W] = 5'(i + 1);
        end
        req_valid = 3'b001;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b001) begin nErrors++; $display("FAIL flush_g0 actual=%b required=001", req_ready); end
        tick();
        req_valid = 3'b010;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b010) begin nErrors++; $display("FAIL flush_g1 actual=%b required=010", req_ready); end
        tick();
        flush = 1'b1; req_valid = 3'b111;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b000) begin nErrors++; $display("FAIL flush_nogrant actual=%b required=000", req_ready); end
        tick();
        flush = 1'b0;
        @(negedge clock);
        nChecks++; if (resp_valid !== 1'b0) begin nErrors++; $display("FAIL flush_cleared actual=%b required=0", resp_valid); end
        nChecks++; if (req_ready !== 3'b100) begin nErrors++; $display("FAIL flush_next_grant actual=%b required=100", req_ready); end
        tick();
        req_valid = '0; resp_ready = 1'b1; nResp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                nResp++;
                nChecks++; if (resp_src !== 2'd2 || resp_tag !== 5'd3) begin nErrors++; $display("FAIL flush_resp actual=%0d/%0d required=2/3", resp_src, resp_tag); end
            end
            tick();
        end
        nChecks++; if (nResp != 1) begin nErrors++; $display("FAIL flush_count actual=%0d required=1", nResp); end
    endtask

    task automatic test_reset_mid();
        int nResp;
        apply_reset();
        req_valid = 3'b010;
        @(negedge clock);
        tick();
        req_valid = 3'b100;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b100) begin nErrors++; $display("FAIL rmid_g2 actual=%b required=100", req_ready); end
        tick();
        reset = 1'b0; req_valid = 3'b111;
        @(negedge clock);
        nChecks++; if (req_ready !== 3'b000) begin nErrors++; $display("FAIL rmid_ready_in_reset actual=%b required=000", req_ready); end
        tick();
        reset = 1'b1;
        @(negedge clock);
        nChecks++; if (resp_valid !== 1'b0) begin nErrors++; $display("FAIL rmid_valid actual=%b required=0", resp_valid); end
        nChecks++; if (req_ready !== 3'b001) begin nErrors++; $display("FAIL rmid_first_grant actual=%b required=001", req_ready); end
        tick();
        req_valid = '0; resp_ready = 1'b1; nResp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                nResp++;
                nChecks++; if (resp_src !== 2'd0) begin nErrors++; $display("FAIL rmid_resp_src actual=%0d required=0", resp_src); end
            end
            tick();
        end
        nChecks++; if (nResp != 1) begin nErrors++; $display("FAIL rmid_count actual=%0d required=1", nResp); end
    endtask

    task automatic test_random();
        item_t              q[$];
        item_t              it;
        int                 lastG, pick;
        logic [NUM_REQ-1:0] expReady;
        logic               expRv;
        apply_reset();
        lastG = NUM_REQ - 1;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                req_valid = 3'($urandom);
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_raw[i*40 +: 40] = rndRaw();
                    req_tag[i*TAG_W +: TAG_W] = 5'($urandom);
                end
                resp_ready = ($urandom_range(0, 9) < 7);
            end else begin
                req_valid = '0; resp_ready = 1'b1;
            end
            @(negedge clock);
            // At most two operations fit; a third is accepted only if one leaves
            expReady = '0;
            pick = rrPick(req_valid, lastG);
            if (pick >= 0 && (q.size() < 2 || resp_ready)) expReady[pick] = 1'b1;
            nChecks++; if (req_ready !== expReady) begin nErrors++; $display("FAIL rand_ready c=%0d actual=%b required=%b", c, req_ready, expReady); end
            expRv = (q.size() > 0) && (q[0].cyc <= c - 2);
            nChecks++; if (resp_valid !== expRv) begin nErrors++; $display("FAIL rand_resp_valid c=%0d actual=%b required=%b", c, resp_valid, expRv); end
            if (resp_valid && q.size() > 0) begin
                nChecks++;
                if (resp_data !== unitModel(q[0].raw) || resp_src !== q[0].src || resp_tag !== q[0].tag) begin
                    nErrors++; $display("FAIL rand_resp c=%0d actual=%h/%0d/%0d required=%h/%0d/%0d", c, resp_data, resp_src, resp_tag, unitModel(q[0].raw), q[0].src, q[0].tag);
                end
                if (resp_ready) void'(q.pop_front());
            end
            if (|expReady) begin
                it.raw = req_raw[pick*40 +: 40];
                it.tag = req_tag[pick*TAG_W +: TAG_W];
                it.src = 2'(pick);
                it.cyc = c;
                q.push_back(it);
                lastG = pick;
            end
            tick();
        end
        nChecks++; if (q.size() != 0) begin nErrors++; $display("FAIL rand_drain actual=%0d required=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
